// File: rtl/updown_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
package updown_pkg;

    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned LEGS_W_DEF = 8;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sweep_counter.sv
// Loadable up/down counter; load has priority over count enable, holds when idle.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val on the next edge
//   load_val   : value to load
//   en         : step by one in the direction given by up
//   up         : 1 = increment, 0 = decrement
//   count      : registered counter value
module sweep_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en) begin
            count_q <= up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Command-driven triangle-sweep controller driving a sweep_counter between
// latched low/high bounds for a programmed number of legs.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_lo/cmd_hi         : sweep bounds (unsigned)
//   cmd_legs              : number of half-sweeps, 0 treated as 1
//   hold, abort           : freeze / terminate an active sweep
//   count, dir            : counter value and direction (1 = up)
//   busy, done, err       : sweeping, one-cycle completion, one-cycle reject
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned LEGS_W = LEGS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_lo,
    input  logic [WIDTH-1:0]  cmd_hi,
    input  logic [LEGS_W-1:0] cmd_legs,
    input  logic              hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic                dir_q, dir_d;
    logic [LEGS_W-1:0]   legs_q, legs_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic                err_q, err_d;

    logic                cnt_load;
    logic [WIDTH-1:0]    cnt_load_val;
    logic                cnt_en;
    logic                cnt_up;
    logic [WIDTH-1:0]    count_w;
    logic [WIDTH-1:0]    count_inc;
    logic [WIDTH-1:0]    count_dec;

    assign count_inc = count_w + WIDTH'(1);
    assign count_dec = count_w - WIDTH'(1);

    sweep_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .up       (cnt_up),
        .count    (count_w)
    );

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            legs_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            legs_q  <= legs_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter control; the step's result is compared against
    // the latched bound so the leg ends on the edge that reaches it.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        legs_d       = legs_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = cmd_lo;
        cnt_en       = 1'b0;
        cnt_up       = dir_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_lo > cmd_hi) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        dir_d    = 1'b1;
                        lo_d     = cmd_lo;
                        hi_d     = cmd_hi;
                        if (cmd_lo == cmd_hi) begin
                            state_d = DONE;
                        end else begin
                            legs_d  = (cmd_legs == '0) ? LEGS_W'(1) : cmd_legs;
                            state_d = UP;
                        end
                    end
                end
            end
            UP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b1;
                    if (count_inc == hi_q) begin
                        legs_d = legs_q - LEGS_W'(1);
                        if (legs_q == LEGS_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = DOWN;
                            dir_d   = 1'b0;
                        end
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    cnt_up = 1'b0;
                    if (count_dec == lo_q) begin
                        legs_d = legs_q - LEGS_W'(1);
                        if (legs_q == LEGS_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            state_d = UP;
                            dir_d   = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status decodes straight from the state register.
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == UP) || (state_q == DOWN);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign count     = count_w;
    assign dir       = dir_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed self-checking bench for updown_sweep_ctrl.
module tb_updown_sweep_ctrl;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned LEGS_W = 8;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_lo;
    logic [WIDTH-1:0]  cmd_hi;
    logic [LEGS_W-1:0] cmd_legs;
    logic              hold;
    logic              abort;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    int tri_cnt[7] = '{2, 3, 4, 5, 4, 3, 2};
    int tri_dir[7] = '{1, 1, 1, 0, 0, 0, 0};

    updown_sweep_ctrl #(
        .WIDTH  (WIDTH),
        .LEGS_W (LEGS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_lo    (cmd_lo),
        .cmd_hi    (cmd_hi),
        .cmd_legs  (cmd_legs),
        .hold      (hold),
        .abort     (abort),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command for exactly one edge; afterwards the first post-accept cycle is visible.
    task automatic send(input int lo, input int hi, input int legs);
        cmd_lo    = WIDTH'(lo);
        cmd_hi    = WIDTH'(hi);
        cmd_legs  = LEGS_W'(legs);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_lo    = 4'd1;
        cmd_hi    = 4'd2;
        cmd_legs  = 8'd1;
        hold      = 1'b0;
        abort     = 1'b0;

        // Reset state, with a command offered during reset that must be ignored.
        tick();
        tick();
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_dir", 32'(dir), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b0;
        reset     = 1'b0;
        tick();

        // Triangle lo=2 hi=5 legs=2.
        send(2, 5, 2);
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("tri_cnt_c%0d", i + 1), 32'(count), 32'(tri_cnt[i]));
            check_eq($sformatf("tri_done_c%0d", i + 1), 32'(done), (i == 6) ? 1 : 0);
            check_eq($sformatf("tri_ready_c%0d", i + 1), 32'(cmd_ready), 0);
            if (i < 6) begin
                check_eq($sformatf("tri_dir_c%0d", i + 1), 32'(dir), 32'(tri_dir[i]));
                check_eq($sformatf("tri_busy_c%0d", i + 1), 32'(busy), 1);
            end
            tick();
        end
        check_eq("tri_ready_after", 32'(cmd_ready), 1);
        check_eq("tri_done_after", 32'(done), 0);
        check_eq("tri_cnt_after", 32'(count), 2);

        // Degenerate lo==hi.
        send(7, 7, 3);
        check_eq("eq_count", 32'(count), 7);
        check_eq("eq_done", 32'(done), 1);
        check_eq("eq_ready", 32'(cmd_ready), 0);
        tick();
        check_eq("eq_ready_after", 32'(cmd_ready), 1);
        check_eq("eq_done_after", 32'(done), 0);

        // Illegal lo>hi.
        send(9, 3, 1);
        check_eq("bad_err", 32'(err), 1);
        check_eq("bad_count", 32'(count), 7);
        check_eq("bad_ready", 32'(cmd_ready), 1);
        check_eq("bad_busy", 32'(busy), 0);
        tick();
        check_eq("bad_err_after", 32'(err), 0);
        check_eq("bad_ready_after", 32'(cmd_ready), 1);

        // legs=0 behaves as one leg, full range, no wrap.
        send(0, 15, 0);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("full_cnt_c%0d", i + 1), 32'(count), 32'(i));
            check_eq($sformatf("full_done_c%0d", i + 1), 32'(done), (i == 15) ? 1 : 0);
            tick();
        end
        check_eq("full_cnt_after", 32'(count), 15);
        check_eq("full_ready_after", 32'(cmd_ready), 1);

        // Hold three cycles at count=4 delays done by three.
        send(2, 6, 1);
        tick();
        tick();
        check_eq("hold_c3", 32'(count), 4);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("hold_frz_%0d", i), 32'(count), 4);
            check_eq($sformatf("hold_busy_%0d", i), 32'(busy), 1);
            check_eq($sformatf("hold_done_%0d", i), 32'(done), 0);
        end
        hold = 1'b0;
        tick();
        check_eq("hold_c7", 32'(count), 5);
        check_eq("hold_done_c7", 32'(done), 0);
        tick();
        check_eq("hold_c8", 32'(count), 6);
        check_eq("hold_done_c8", 32'(done), 1);
        tick();
        check_eq("hold_ready_after", 32'(cmd_ready), 1);

        // Abort together with hold at count=4.
        send(2, 6, 1);
        tick();
        tick();
        check_eq("abort_c3", 32'(count), 4);
        hold  = 1'b1;
        abort = 1'b1;
        tick();
        hold  = 1'b0;
        abort = 1'b0;
        check_eq("abort_count", 32'(count), 4);
        check_eq("abort_ready", 32'(cmd_ready), 1);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("abort_nodone_%0d", i), 32'(done), 0);
            check_eq($sformatf("abort_hold_cnt_%0d", i), 32'(count), 4);
        end

        // Reset mid-sweep at count=3.
        send(1, 8, 1);
        tick();
        tick();
        check_eq("mrst_c3", 32'(count), 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mrst_count", 32'(count), 0);
        check_eq("mrst_busy", 32'(busy), 0);
        check_eq("mrst_ready", 32'(cmd_ready), 1);
        check_eq("mrst_dir", 32'(dir), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("mrst_nodone_%0d", i), 32'(done), 0);
        end

        // Back-to-back: second command held valid, bounds changed mid-sweep.
        cmd_lo    = 4'd1;
        cmd_hi    = 4'd3;
        cmd_legs  = 8'd1;
        cmd_valid = 1'b1;
        tick();
        check_eq("b2b_c1", 32'(count), 1);
        cmd_lo   = 4'd4;
        cmd_hi   = 4'd6;
        cmd_legs = 8'd1;
        tick();
        check_eq("b2b_c2", 32'(count), 2);
        check_eq("b2b_ready_c2", 32'(cmd_ready), 0);
        tick();
        check_eq("b2b_c3", 32'(count), 3);
        check_eq("b2b_done_c3", 32'(done), 1);
        check_eq("b2b_ready_c3", 32'(cmd_ready), 0);
        tick();
        check_eq("b2b_ready_c4", 32'(cmd_ready), 1);
        check_eq("b2b_c4", 32'(count), 3);
        tick();
        cmd_valid = 1'b0;
        check_eq("b2b2_c1", 32'(count), 4);
        check_eq("b2b2_busy", 32'(busy), 1);
        tick();
        check_eq("b2b2_c2", 32'(count), 5);
        tick();
        check_eq("b2b2_c3", 32'(count), 6);
        check_eq("b2b2_done", 32'(done), 1);
        tick();
        check_eq("b2b2_ready", 32'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
